// File: rtl/sdram_wb_bridge.sv
// Wishbone classic slave that streams burst beats into the SDRAM core's
// ping-pong write FIFO and pulls read beats from its read FIFO.
module sdram_wb_bridge #(
  parameter logic [31:0] READ_TIMEOUT = 32'd1000000,
  parameter int          ADDR_WIDTH   = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wbs_cyc,
  input  logic                  i_wbs_stb,
  input  logic                  i_wbs_we,
  input  logic [3:0]            i_wbs_sel,
  input  logic [31:0]           i_wbs_adr,
  input  logic [31:0]           i_wbs_dat,
  output logic [31:0]           o_wbs_dat,
  output logic                  o_wbs_ack,
  output logic                  o_wbs_err,
  input  logic                  sdram_ready,
  output logic                  sdram_write_enable,
  output logic                  sdram_read_enable,
  output logic [ADDR_WIDTH-1:0] app_address,
  output logic                  if_write_strobe,
  output logic [31:0]           if_write_data,
  output logic [3:0]            if_write_mask,
  input  logic [1:0]            if_write_ready,
  output logic [1:0]            if_write_activate,
  input  logic [23:0]           if_write_fifo_size,
  output logic                  of_read_strobe,
  input  logic                  of_read_ready,
  output logic                  of_read_activate,
  input  logic [23:0]           of_read_count,
  input  logic [31:0]           of_read_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ACQ, S_WR_XFER, S_WR_DRAIN,
    S_RD_WAIT, S_RD_SETTLE, S_RD_XFER, S_RD_END
  } state_t;

  state_t      r_state;
  logic [23:0] r_count;
  logic [31:0] r_timeout;

  logic        w_beat;
  logic [23:0] w_count_inc;
  logic        w_unused;

  // The err pulse answers a beat just like ack, so it also masks the beat.
  assign w_beat      = i_wbs_cyc & i_wbs_stb & ~o_wbs_ack & ~o_wbs_err;
  assign w_count_inc = r_count + 24'd1;
  assign w_unused    = &{1'b0, i_wbs_adr[31:ADDR_WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= S_IDLE;
      r_count            <= '0;
      r_timeout          <= '0;
      o_wbs_dat          <= '0;
      o_wbs_ack          <= 1'b0;
      o_wbs_err          <= 1'b0;
      sdram_write_enable <= 1'b0;
      sdram_read_enable  <= 1'b0;
      app_address        <= '0;
      if_write_strobe    <= 1'b0;
      if_write_data      <= '0;
      if_write_mask      <= '0;
      if_write_activate  <= '0;
      of_read_strobe     <= 1'b0;
      of_read_activate   <= 1'b0;
    end else begin
      // NOTE: pulses default low here so every later branch only has to raise them.
      o_wbs_ack       <= 1'b0;
      o_wbs_err       <= 1'b0;
      if_write_strobe <= 1'b0;
      of_read_strobe  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_beat && sdram_ready) begin
            app_address <= i_wbs_adr[ADDR_WIDTH-1:0];
            if (i_wbs_we) begin
              sdram_write_enable <= 1'b1;
              r_state            <= S_WR_ACQ;
            end else begin
              sdram_read_enable <= 1'b1;
              r_timeout         <= '0;
              r_state           <= S_RD_WAIT;
            end
          end
        end

        // A filled side is released here, one cycle after its last strobe.
        S_WR_ACQ: begin
          if (if_write_activate != 2'b00) begin
            if_write_activate <= 2'b00;
          end else if (!i_wbs_cyc) begin
            r_state <= S_WR_DRAIN;
          end else if (if_write_ready != 2'b00) begin
            if_write_activate <= if_write_ready[0] ? 2'b01 : 2'b10;
            r_count           <= '0;
            r_state           <= S_WR_XFER;
          end
        end

        S_WR_XFER: begin
          if (!i_wbs_cyc) begin
            if_write_activate <= 2'b00;
            r_state           <= S_WR_DRAIN;
          end else if (w_beat) begin
            if_write_strobe <= 1'b1;
            if_write_data   <= i_wbs_dat;
            if_write_mask   <= ~i_wbs_sel;
            o_wbs_ack       <= 1'b1;
            r_count         <= w_count_inc;
            if (w_count_inc >= if_write_fifo_size) r_state <= S_WR_ACQ;
          end
        end

        S_WR_DRAIN: begin
          if (if_write_ready == 2'b11) begin
            sdram_write_enable <= 1'b0;
            r_state            <= S_IDLE;
          end
        end

        S_RD_WAIT: begin
          if (!i_wbs_cyc) begin
            of_read_activate  <= 1'b0;
            sdram_read_enable <= 1'b0;
            r_state           <= S_RD_END;
          end else if (of_read_activate) begin
            of_read_activate <= 1'b0;
            r_timeout        <= '0;
          end else if (of_read_ready) begin
            of_read_activate <= 1'b1;
            r_count          <= '0;
            r_state          <= S_RD_SETTLE;
          end else if (r_timeout == READ_TIMEOUT - 32'd1) begin
            o_wbs_err         <= 1'b1;
            sdram_read_enable <= 1'b0;
            r_state           <= S_IDLE;
          end else begin
            r_timeout <= r_timeout + 32'd1;
          end
        end

        S_RD_SETTLE: begin
          if (!i_wbs_cyc) begin
            of_read_activate  <= 1'b0;
            sdram_read_enable <= 1'b0;
            r_state           <= S_RD_END;
          end else begin
            r_state <= S_RD_XFER;
          end
        end

        S_RD_XFER: begin
          if (!i_wbs_cyc) begin
            of_read_activate  <= 1'b0;
            sdram_read_enable <= 1'b0;
            r_state           <= S_RD_END;
          end else if (w_beat) begin
            o_wbs_dat      <= of_read_data;
            o_wbs_ack      <= 1'b1;
            of_read_strobe <= 1'b1;
            r_count        <= w_count_inc;
            if (w_count_inc >= of_read_count) begin
              r_timeout <= '0;
              r_state   <= S_RD_WAIT;
            end
          end
        end

        S_RD_END: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
